// File: rtl/lfsr_rng.sv
// Parametrised Fibonacci LFSR random-number generator with a request/valid
// handshake, optional rejection sampling against RANGE, runtime seed load
// and an all-zero lock-up guard.
module lfsr_rng #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hD008,
  parameter logic [WIDTH-1:0] SEED      = 16'h3CF5,
  parameter int unsigned      OUT_W     = 3,
  parameter int unsigned      RANGE     = 8,
  parameter int unsigned      MAX_RETRY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             free_run_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic             fallback,
  output logic [WIDTH-1:0] state_out
);

  localparam int unsigned    CW        = $clog2(OUT_W + 1);
  localparam int unsigned    RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [OUT_W:0] RANGE_C   = (OUT_W + 1)'(RANGE);
  localparam bit             NO_REJECT = (RANGE >= (1 << OUT_W));

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } fsm_t;

  fsm_t             r_fsm,   w_fsm_nxt;
  logic [WIDTH-1:0] r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;
  logic [RW-1:0]    r_retry, w_retry_nxt;
  logic             r_valid, w_valid_nxt;
  logic [OUT_W-1:0] r_out,   w_out_nxt;
  logic             r_fbk,   w_fbk_nxt;

  logic             w_fb;
  logic [WIDTH-1:0] w_step;
  logic [OUT_W-1:0] w_cand;
  logic             w_cand_ok;
  logic             w_do_step;

  assign w_fb      = ^(r_state & TAPS);
  assign w_step    = {r_state[WIDTH-2:0], w_fb};
  assign w_cand    = r_state[WIDTH-1 -: OUT_W];
  assign w_cand_ok = NO_REJECT || ({1'b0, w_cand} < RANGE_C);

  // Handshake FSM: next state, shift/retry counters and delivery outputs
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_valid_nxt = 1'b0;
    w_out_nxt   = r_out;
    w_fbk_nxt   = 1'b0;
    w_do_step   = 1'b0;
    if (seed_load) begin
      // A seed load aborts any request in flight without delivering
      w_fsm_nxt   = S_IDLE;
      w_cnt_nxt   = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          w_retry_nxt = '0;
          if (req) begin
            w_fsm_nxt = S_SHIFT;
            w_cnt_nxt = '0;
          end else if (free_run_en) begin
            w_do_step = 1'b1;
          end
        end
        S_SHIFT: begin
          w_do_step = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(OUT_W - 1)) w_fsm_nxt = S_CHECK;
        end
        S_CHECK: begin
          if (w_cand_ok) begin
            w_out_nxt   = w_cand;
            w_valid_nxt = 1'b1;
            w_retry_nxt = '0;
            w_fsm_nxt   = S_IDLE;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            w_retry_nxt = r_retry + RW'(1);
            w_cnt_nxt   = '0;
            w_fsm_nxt   = S_SHIFT;
          end else begin
            w_out_nxt   = '0;
            w_fbk_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
            w_retry_nxt = '0;
            w_fsm_nxt   = S_IDLE;
          end
        end
        default: w_fsm_nxt = S_IDLE;
      endcase
    end
  end

  // LFSR next state: seed load, then lock-up recovery, then one step
  always_comb begin
    w_state_nxt = r_state;
    if (seed_load)           w_state_nxt = (seed_in == '0) ? SEED : seed_in;
    else if (r_state == '0)  w_state_nxt = SEED;
    else if (w_do_step)      w_state_nxt = w_step;
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_state <= SEED;
      r_cnt   <= '0;
      r_retry <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_fbk   <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_valid <= w_valid_nxt;
      r_out   <= w_out_nxt;
      r_fbk   <= w_fbk_nxt;
    end
  end

  assign busy      = (r_fsm != S_IDLE);
  assign rnd_valid = r_valid;
  assign rnd_out   = r_out;
  assign fallback  = r_fbk;
  assign state_out = r_state;

endmodule

// File: doc/lfsr_rng.md
Name: lfsr_rng

Overview:
Parametrised Fibonacci LFSR random-number generator. Successor to the fixed 16-bit/3-bit game LFSR: configurable width, taps, seed and output width, with runtime seed load and all-zero lock-up protection. Adds a request/valid handshake that returns a fresh OUT_W-bit value, optionally range-limited by rejection sampling. Sits beside game logic (ball serve direction/speed, AI jitter) in the single system clock domain.

Parameters:
WIDTH, 16, LFSR state width (≥ OUT_W+1, ≤ 32)
TAPS, 16'hD008, feedback mask; bit i set → state[i] feeds the XOR (default x^16+x^15+x^13+x^4+1)
SEED, 16'h3CF5, reset/fallback state; must be non-zero
OUT_W, 3, bits per delivered random value
RANGE, 8, delivered values are < RANGE (1..2^OUT_W); 2^OUT_W disables rejection
MAX_RETRY, 4, rejections allowed before fallback

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
free_run_en  in  1  when idle, advance state every cycle
seed_load  in  1  load seed_in into state this cycle
seed_in  in  WIDTH  runtime seed
req  in  1  request one random value
busy  out  1  request in progress
rnd_valid  out  1  one-cycle pulse, rnd_out valid
rnd_out  out  OUT_W  delivered value
fallback  out  1  high with rnd_valid when retries exhausted
state_out  out  WIDTH  current LFSR state (debug)

Behaviour:
- Reset (async, immediate): state=SEED, FSM=IDLE, busy=0, rnd_valid=0, rnd_out=0, fallback=0, retry count=0.
- Step: fb = ^(state & TAPS); state <= {state[WIDTH-2:0], fb}. One step per cycle max.
- Candidate = state[WIDTH-1:WIDTH-OUT_W].
- Priority per cycle: seed_load > FSM shift > free-run shift.
- seed_load: state <= (seed_in==0) ? SEED : seed_in. If FSM busy, FSM aborts to IDLE, no rnd_valid, retry=0.
- Lock-up guard: if state==0 at any edge (illegal TAPS), state <= SEED instead of step.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: busy=0. req=1 at edge k → SHIFT, shift counter=0. req ignored while busy (no queueing). free-run steps only in IDLE when req=0.
  - SHIFT: busy=1; one step per cycle, edges k+1..k+OUT_W, then → CHECK.
  - CHECK (edge k+OUT_W+1): if candidate < RANGE or RANGE==2^OUT_W → rnd_out=candidate, rnd_valid=1 for one cycle, fallback=0, → IDLE. Else if retry < MAX_RETRY → retry+1, → SHIFT. Else → rnd_out=0, fallback=1, rnd_valid=1, → IDLE. Retry clears on IDLE entry.
- No state step in CHECK cycle.
- Latency: OUT_W+1 cycles from acceptance edge to rnd_valid; +OUT_W+1 per rejection.
- rnd_out holds last delivered value until next delivery; rnd_valid/fallback are single-cycle.
- req held high: new request accepted the cycle after returning to IDLE (back-to-back every OUT_W+2 cycles).
- Comparisons unsigned; RANGE compared at OUT_W+1 bits to avoid overflow.

Test Plan:
1. Reset, defaults, free_run_en=0, req pulse → states 0x79EB, 0xF3D7, 0xE7AF after 3 shifts; rnd_valid at 4th edge after acceptance, rnd_out=7, fallback=0.
2. RANGE=6, same stimulus → candidate 7 rejected; states 0xCF5F, 0x9EBF, 0x3D7F; rnd_out=1 after 8 cycles total, fallback=0.
3. RANGE=1, MAX_RETRY=1 → two rejections then rnd_out=0, fallback=1, rnd_valid one cycle; busy drops same edge.
4. seed_load with seed_in=0 → state_out=0x3CF5; seed_in=0x1234 → 0x1234; seed_load mid-SHIFT → busy=0, no rnd_valid, state=seed.
5. free_run_en=1 idle for 2 cycles from reset → 0x79EB, 0xF3D7; req asserted while busy ignored (single rnd_valid); rst asserted mid-SHIFT without clock edge → outputs immediately at reset values.
6. TAPS=0 (forces state 0 via shift path) → state reloads SEED on the zero edge, never stuck at 0.
